// File: rtl/display_arbiter.sv
// Round-robin time-sharing of the 4-digit display among up to four number sources,
// with dwell measured in strobe pulses, a manual step key and a freeze key.
module display_arbiter #(
  parameter int w           = 16,
  parameter int dwell_width = 3
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           en,
  input  logic [3:0]     req,
  input  logic [4*w-1:0] num,
  input  logic           key_next,
  input  logic           key_hold,
  output logic [w-1:0]   num_out,
  output logic [3:0]     grant,
  output logic [1:0]     sel,
  output logic [3:0]     dots_out,
  output logic           idle
);

  typedef enum logic [1:0] {IDLE, SHOW, HOLD} state_t;

  state_t                 state;
  state_t                 state_next;
  logic [dwell_width-1:0] dwell_cnt;
  logic [dwell_width-1:0] dwell_next;
  logic [1:0]             sel_next;
  logic                   key_next_q;
  logic                   step_q;
  logic [1:0]             search_idx;
  logic                   search_hit;
  logic [1:0]             cand;
  logic                   expire;

  // Scanning offsets 4..1 lets the smallest offset win; offset 4 is the current
  // source itself, so it is chosen only when nobody else requests.
  always_comb begin
    search_hit = 1'b0;
    search_idx = sel;
    cand       = sel;
    for (int i = 4; i >= 1; i--) begin
      cand = sel + 2'(i);
      if (req[cand]) begin
        search_hit = 1'b1;
        search_idx = cand;
      end
    end
  end

  assign expire = (dwell_cnt == {dwell_width{1'b1}});

  always_comb begin
    state_next = state;
    sel_next   = sel;
    dwell_next = dwell_cnt;
    case (state)
      IDLE: begin
        if (search_hit) begin
          sel_next   = search_idx;
          dwell_next = '0;
          state_next = key_hold ? HOLD : SHOW;
        end
      end
      default: begin
        state_next = key_hold ? HOLD : SHOW;
        if (!req[sel]) begin
          if (search_hit) begin
            sel_next   = search_idx;
            dwell_next = '0;
          end else begin
            state_next = IDLE;
          end
        end else if (step_q) begin
          sel_next   = search_idx;
          dwell_next = '0;
        end else if (state == SHOW && en) begin
          if (expire) begin
            sel_next   = search_idx;
            dwell_next = '0;
          end else begin
            dwell_next = dwell_cnt + 1'b1;
          end
        end
      end
    endcase
  end

  // The step event is registered once more so a key press moves the grant two
  // cycles after the key level rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      sel        <= 2'd3;
      dwell_cnt  <= '0;
      grant      <= 4'b0000;
      num_out    <= '0;
      idle       <= 1'b1;
      key_next_q <= 1'b0;
      step_q     <= 1'b0;
    end else begin
      state      <= state_next;
      sel        <= sel_next;
      dwell_cnt  <= dwell_next;
      key_next_q <= key_next;
      step_q     <= key_next & ~key_next_q;
      if (state_next == IDLE) begin
        grant   <= 4'b0000;
        num_out <= '0;
        idle    <= 1'b1;
      end else begin
        grant   <= 4'b0001 << sel_next;
        num_out <= num[sel_next*w +: w];
        idle    <= 1'b0;
      end
    end
  end

  assign dots_out = grant;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter: an integer-level reference model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_display_arbiter;

  localparam int W         = 16;
  localparam int DW        = 3;
  localparam int DWELL_LEN = 1 << DW;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           en = 1'b0;
  logic [3:0]     req = 4'b0000;
  logic [4*W-1:0] num;
  logic           key_next = 1'b0;
  logic           key_hold = 1'b0;
  logic [W-1:0]   num_out;
  logic [3:0]     grant;
  logic [1:0]     sel;
  logic [3:0]     dots_out;
  logic           idle;

  int checks = 0;
  int errors = 0;

  display_arbiter #(.w(W), .dwell_width(DW)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .req(req), .num(num),
    .key_next(key_next), .key_hold(key_hold), .num_out(num_out),
    .grant(grant), .sel(sel), .dots_out(dots_out), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit granted;
    int src;
    int cnt;
    bit hold;
  } mstate_t;

  mstate_t      ms;
  bit           m_kq;
  bit           m_edge;
  logic [W-1:0] m_num;

  function automatic int pick(int from, logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (from + k) % 4;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic mstate_t model_next(mstate_t s, bit step, logic [3:0] r, bit e, bit kh);
    mstate_t n;
    int p;
    n = s;
    p = pick(s.src, r);
    if (!s.granted) begin
      if (p >= 0) begin
        n.granted = 1'b1;
        n.src = p;
        n.cnt = 0;
      end
    end else if (!r[s.src]) begin
      if (p >= 0) begin
        n.src = p;
        n.cnt = 0;
      end else begin
        n.granted = 1'b0;
      end
    end else if (step) begin
      n.src = p;
      n.cnt = 0;
    end else if (!s.hold && e) begin
      if (s.cnt + 1 == DWELL_LEN) begin
        n.src = p;
        n.cnt = 0;
      end else begin
        n.cnt = s.cnt + 1;
      end
    end
    n.hold = kh;
    return n;
  endfunction

  function automatic logic [W-1:0] model_num(mstate_t s, logic [4*W-1:0] nv);
    return s.granted ? nv[s.src*W +: W] : '0;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ms     <= '{granted: 1'b0, src: 3, cnt: 0, hold: 1'b0};
      m_kq   <= 1'b0;
      m_edge <= 1'b0;
      m_num  <= '0;
    end else begin
      ms     <= model_next(ms, m_edge, req, en, key_hold);
      m_num  <= model_num(model_next(ms, m_edge, req, en, key_hold), num);
      m_kq   <= key_next;
      m_edge <= key_next && !m_kq;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      checkOutput("model.grant", 64'(grant), 64'(ms.granted ? (4'b0001 << ms.src) : 4'b0000));
      checkOutput("model.dots", 64'(dots_out), 64'(ms.granted ? (4'b0001 << ms.src) : 4'b0000));
      checkOutput("model.sel", 64'(sel), 64'(ms.src[1:0]));
      checkOutput("model.idle", 64'(idle), 64'(!ms.granted));
      checkOutput("model.num_out", 64'(num_out), 64'(m_num));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic e, input logic kn, input logic kh);
    req      = r;
    en       = e;
    key_next = kn;
    key_hold = kh;
    tick();
  endtask

  task automatic pulse_en(input logic [3:0] r, input logic kn, input logic kh, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(r, 1'b1, kn, kh);
      repeat (4) applyStimulus(r, 1'b0, kn, kh);
    end
  endtask

  // Reset pulse released before the following clock edge.
  task automatic do_reset();
    tick();
    reset_n = 1'b0;
    #4;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    num = {16'h4444, 16'h3333, 16'h2222, 16'h1111};

    #12;
    checkOutput("reset.grant", 64'(grant), 64'h0);
    checkOutput("reset.sel", 64'(sel), 64'h3);
    checkOutput("reset.idle", 64'(idle), 64'h1);
    checkOutput("reset.num_out", 64'(num_out), 64'h0);
    checkOutput("reset.dots", 64'(dots_out), 64'h0);
    tick();
    reset_n = 1'b1;
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("idle.grant", 64'(grant), 64'h0);

    applyStimulus(4'b0110, 1'b0, 1'b0, 1'b0);
    checkOutput("first.grant", 64'(grant), 64'h2);
    checkOutput("first.sel", 64'(sel), 64'h1);
    checkOutput("first.idle", 64'(idle), 64'h0);
    checkOutput("first.num_out", 64'(num_out), 64'h2222);

    do_reset();
    applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0);
    checkOutput("dwell.start", 64'(grant), 64'h1);
    for (int p = 0; p < 4; p++) begin
      pulse_en(4'b1111, 1'b0, 1'b0, DWELL_LEN - 1);
      checkOutput("dwell.before", 64'(grant), 64'(4'b0001 << p));
      pulse_en(4'b1111, 1'b0, 1'b0, 1);
      checkOutput("dwell.after", 64'(grant), 64'(4'b0001 << ((p + 1) % 4)));
    end

    applyStimulus(4'b1100, 1'b0, 1'b0, 1'b0);
    checkOutput("drop.to2", 64'(grant), 64'h4);
    applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0);
    checkOutput("drop.to3", 64'(grant), 64'h8);
    checkOutput("drop.sel3", 64'(sel), 64'h3);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("drop.idle", 64'(idle), 64'h1);
    checkOutput("drop.num_out", 64'(num_out), 64'h0);
    checkOutput("drop.sel", 64'(sel), 64'h3);
    checkOutput("drop.grant", 64'(grant), 64'h0);

    applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0);
    checkOutput("hold.start", 64'(grant), 64'h1);
    pulse_en(4'b1111, 1'b0, 1'b0, 3);
    applyStimulus(4'b1111, 1'b0, 1'b0, 1'b1);
    pulse_en(4'b1111, 1'b0, 1'b1, 40);
    checkOutput("hold.frozen", 64'(grant), 64'h1);
    applyStimulus(4'b1111, 1'b0, 1'b1, 1'b1);
    checkOutput("hold.step_t1", 64'(grant), 64'h1);
    applyStimulus(4'b1111, 1'b0, 1'b1, 1'b1);
    checkOutput("hold.step_t2", 64'(grant), 64'h2);
    applyStimulus(4'b1111, 1'b0, 1'b0, 1'b1);
    checkOutput("hold.one_step", 64'(grant), 64'h2);
    applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0);
    pulse_en(4'b1111, 1'b0, 1'b0, 3);
    applyStimulus(4'b1111, 1'b0, 1'b0, 1'b1);
    pulse_en(4'b1111, 1'b0, 1'b1, 10);
    applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0);
    pulse_en(4'b1111, 1'b0, 1'b0, 4);
    checkOutput("resume.before", 64'(grant), 64'h2);
    pulse_en(4'b1111, 1'b0, 1'b0, 1);
    checkOutput("resume.after", 64'(grant), 64'h4);

    do_reset();
    applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0);
    pulse_en(4'b1111, 1'b0, 1'b0, DWELL_LEN - 1);
    applyStimulus(4'b1111, 1'b0, 1'b1, 1'b0);
    checkOutput("collide.pre", 64'(sel), 64'h0);
    applyStimulus(4'b1111, 1'b1, 1'b1, 1'b0);
    checkOutput("collide.sel", 64'(sel), 64'h1);
    applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0);
    checkOutput("collide.stable", 64'(sel), 64'h1);
    num[31:16] = 16'hABCD;
    applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0);
    checkOutput("live.num_out", 64'(num_out), 64'hABCD);

    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checkOutput("async.grant", 64'(grant), 64'h0);
    checkOutput("async.sel", 64'(sel), 64'h3);
    checkOutput("async.idle", 64'(idle), 64'h1);
    checkOutput("async.num_out", 64'(num_out), 64'h0);
    checkOutput("async.dots", 64'(dots_out), 64'h0);
    #2;
    reset_n = 1'b1;
    applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0);
    checkOutput("restart.grant", 64'(grant), 64'h1);
    checkOutput("restart.sel", 64'(sel), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
